// File: rtl/fifo_cascade_sync.sv
// fifo_cascade_sync: single-clock cascade of NUM_STAGES FIFO stages.
// Words enter stage 0 and move one stage per cycle whenever the next stage has
// room. They leave from the last stage in standard (registered, 1-cycle) or
// first-word-fall-through form. The block also keeps a total occupancy count
// and registered status flags.
//
// Handshake: a write is taken on any edge with wr_en && !full. A read/pop is
// taken on any edge with rd_en && !empty. A request against the opposite flag
// is dropped and reported one cycle later on overflow/underflow.
module fifo_cascade_sync #(
  parameter int DATA_W            = 36,
  parameter int STAGE_DEPTH       = 512,
  parameter int NUM_STAGES        = 2,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = NUM_STAGES*STAGE_DEPTH-4,
  parameter int PROG_EMPTY_THRESH = 4,
  parameter int CNT_W             = $clog2(NUM_STAGES*STAGE_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              empty,
  output logic [CNT_W-1:0]  data_count,
  output logic              prog_full,
  output logic              prog_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW   = $clog2(STAGE_DEPTH);
  localparam int LAST = NUM_STAGES-1;

  typedef logic [AW:0]   scnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam scnt_t             DEPTH_C = scnt_t'(STAGE_DEPTH);
  localparam logic [CNT_W-1:0]  PF_C    = CNT_W'(PROG_FULL_THRESH);
  localparam logic [CNT_W-1:0]  PE_C    = CNT_W'(PROG_EMPTY_THRESH);

  logic [DATA_W-1:0] mem [NUM_STAGES][STAGE_DEPTH];
  scnt_t             cnt     [NUM_STAGES];
  ptr_t              wr_ptr  [NUM_STAGES];
  ptr_t              rd_ptr  [NUM_STAGES];

  logic              push    [NUM_STAGES];
  logic              pop     [NUM_STAGES];
  logic [DATA_W-1:0] in_data [NUM_STAGES];
  scnt_t             cnt_nxt [NUM_STAGES];

  logic              wr_acc;
  logic              rd_acc;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] head_nxt;
  scnt_t             last_left;
  ptr_t              last_rd_nxt;

  // full/empty are registered copies of the post-edge stage counts, so they
  // can gate acceptance directly.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Per-link transfer decisions and next stage counts. Each link uses the
  // pre-edge count of the downstream stage, so a freed slot is seen one hop
  // per cycle.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      push[k]    = 1'b0;
      pop[k]     = 1'b0;
      in_data[k] = din;
    end
    push[0] = wr_acc;
    for (int k = 0; k < NUM_STAGES-1; k++) begin
      pop[k]       = (cnt[k] != '0) && (cnt[k+1] < DEPTH_C);
      push[k+1]    = pop[k];
      in_data[k+1] = mem[k][rd_ptr[k]];
    end
    pop[LAST] = rd_acc;
    for (int k = 0; k < NUM_STAGES; k++) begin
      cnt_nxt[k] = cnt[k] + scnt_t'(push[k]) - scnt_t'(pop[k]);
    end
  end

  // Total occupancy and the head word of the last stage after this edge. The
  // head word is used by the fall-through output.
  always_comb begin
    count_nxt   = data_count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    last_left   = cnt[LAST] - scnt_t'(pop[LAST]);
    last_rd_nxt = rd_ptr[LAST] + ptr_t'(pop[LAST]);
    head_nxt    = dout;
    if (cnt_nxt[LAST] != '0) begin
      if (last_left == '0) head_nxt = in_data[LAST];
      else                 head_nxt = mem[LAST][last_rd_nxt];
    end
  end

  // Stage pointers and counts. Reset discards all stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        cnt[k]    <= '0;
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        cnt[k] <= cnt_nxt[k];
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + ptr_t'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + ptr_t'(1);
      end
    end
  end

  // Stage storage. No reset is needed because the pointers and counts
  // define which entries hold valid words.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= in_data[k];
    end
  end

  // Registered outputs: occupancy, flags, error pulses and read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      valid      <= 1'b0;
      empty      <= 1'b1;
      full       <= 1'b0;
      data_count <= '0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_count <= count_nxt;
      full       <= (cnt_nxt[0] == DEPTH_C);
      empty      <= (cnt_nxt[LAST] == '0);
      prog_full  <= (count_nxt >= PF_C);
      prog_empty <= (count_nxt <= PE_C);
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
      if (FWFT != 0) begin
        dout  <= head_nxt;
        valid <= (cnt_nxt[LAST] != '0);
      end else begin
        valid <= rd_acc;
        if (rd_acc) dout <= mem[LAST][rd_ptr[LAST]];
      end
    end
  end

endmodule

// File: tb/tb_fifo_cascade_sync.sv
// tb_fifo_cascade_sync: directed and randomized checks of the cascade in
// standard mode (dut_std) and first-word-fall-through mode (dut_fw). Both
// instances use the same clock and reset. The reference model is a word
// queue plus the occupancy and flag rules.
module tb_fifo_cascade_sync;

  localparam int DW  = 36;
  localparam int SD  = 16;
  localparam int NS  = 3;
  localparam int CAP = NS*SD;
  localparam int PFT = CAP-4;
  localparam int PET = 4;
  localparam int CW  = $clog2(CAP+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- standard-mode DUT ----------------
  logic          s_wr, s_rd, s_full, s_valid, s_empty, s_pf, s_pe, s_ov, s_un;
  logic [DW-1:0] s_din, s_dout;
  logic [CW-1:0] s_cnt;

  fifo_cascade_sync #(.DATA_W(DW), .STAGE_DEPTH(SD), .NUM_STAGES(NS), .FWFT(0))
  dut_std (
    .clk(clk), .rst_n(rst_n), .wr_en(s_wr), .din(s_din), .full(s_full),
    .rd_en(s_rd), .dout(s_dout), .valid(s_valid), .empty(s_empty),
    .data_count(s_cnt), .prog_full(s_pf), .prog_empty(s_pe),
    .overflow(s_ov), .underflow(s_un)
  );

  // ---------------- FWFT-mode DUT ----------------
  logic          f_wr, f_rd, f_full, f_valid, f_empty, f_pf, f_pe, f_ov, f_un;
  logic [DW-1:0] f_din, f_dout;
  logic [CW-1:0] f_cnt;

  fifo_cascade_sync #(.DATA_W(DW), .STAGE_DEPTH(SD), .NUM_STAGES(NS), .FWFT(1))
  dut_fw (
    .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .din(f_din), .full(f_full),
    .rd_en(f_rd), .dout(f_dout), .valid(f_valid), .empty(f_empty),
    .data_count(f_cnt), .prog_full(f_pf), .prog_empty(f_pe),
    .overflow(f_ov), .underflow(f_un)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] f_q[$];
  logic [DW-1:0] s_last;
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    s_wr = 1'b1; s_rd = 1'b1; s_din = DW'(36'hBAD);
    f_wr = 1'b1; f_rd = 1'b1; f_din = DW'(36'hBAD);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_wr = 1'b0; s_rd = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    exp_q.delete();
    f_q.delete();
    s_last = '0;
    check("rst_s_dout",  s_dout, 0);  check("rst_s_valid", s_valid, 0);
    check("rst_s_empty", s_empty, 1); check("rst_s_full",  s_full, 0);
    check("rst_s_cnt",   s_cnt, 0);   check("rst_s_pe",    s_pe, 1);
    check("rst_s_pf",    s_pf, 0);    check("rst_s_ov",    s_ov, 0);
    check("rst_s_un",    s_un, 0);
    check("rst_f_dout",  f_dout, 0);  check("rst_f_valid", f_valid, 0);
    check("rst_f_empty", f_empty, 1); check("rst_f_full",  f_full, 0);
    check("rst_f_cnt",   f_cnt, 0);   check("rst_f_pe",    f_pe, 1);
    check("rst_f_pf",    f_pf, 0);    check("rst_f_ov",    f_ov, 0);
    check("rst_f_un",    f_un, 0);
  endtask

  // One cycle on the standard-mode DUT, checked against the queue model.
  task automatic s_step(input logic wr, input logic [DW-1:0] d, input logic rd);
    logic wr_acc, rd_acc, ov_e, un_e;
    if (exp_q.size() == 0) check("s_empty_vs_model", s_empty, 1);
    wr_acc = wr && !s_full;
    rd_acc = rd && !s_empty;
    ov_e   = wr && s_full;
    un_e   = rd && s_empty;
    s_wr = wr; s_din = d; s_rd = rd;
    @(posedge clk); #1;
    s_wr = 1'b0; s_rd = 1'b0;
    if (rd_acc) s_last = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (wr_acc) exp_q.push_back(d);
    check("s_valid", s_valid, rd_acc);
    check("s_dout",  s_dout, s_last);
    check("s_count", s_cnt, exp_q.size());
    check("s_pf",    s_pf, exp_q.size() >= PFT);
    check("s_pe",    s_pe, exp_q.size() <= PET);
    check("s_ov",    s_ov, ov_e);
    check("s_un",    s_un, un_e);
    if (exp_q.size() == CAP) check("s_full_at_cap", s_full, 1);
  endtask

  // One cycle on the FWFT DUT: dout must always show the oldest word.
  task automatic f_step(input logic wr, input logic [DW-1:0] d, input logic rd);
    logic wr_acc, rd_acc, ov_e, un_e;
    if (f_q.size() == 0) check("f_empty_vs_model", f_empty, 1);
    wr_acc = wr && !f_full;
    rd_acc = rd && !f_empty;
    ov_e   = wr && f_full;
    un_e   = rd && f_empty;
    f_wr = wr; f_din = d; f_rd = rd;
    @(posedge clk); #1;
    f_wr = 1'b0; f_rd = 1'b0;
    if (rd_acc && f_q.size() > 0) void'(f_q.pop_front());
    if (wr_acc) f_q.push_back(d);
    check("f_valid_eq_ne", f_valid, !f_empty);
    if (!f_empty && f_q.size() > 0) check("f_head", f_dout, f_q[0]);
    check("f_count", f_cnt, f_q.size());
    check("f_pf",    f_pf, f_q.size() >= PFT);
    check("f_pe",    f_pe, f_q.size() <= PET);
    check("f_ov",    f_ov, ov_e);
    check("f_un",    f_un, un_e);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    s_wr = 1'b0; s_rd = 1'b0; s_din = '0;
    f_wr = 1'b0; f_rd = 1'b0; f_din = '0;
    rst_n = 1'b0;

    // 1: fall-through latency and standard read latency
    do_reset();
    for (int i = 0; i < NS; i++) begin
      if (i == 0) s_step(1'b1, DW'(1), 1'b0);
      else        s_step(1'b0, '0, 1'b0);
      check("t1_fall_empty", s_empty, (i < NS-1));
    end
    s_step(1'b0, '0, 1'b1);
    check("t1_dout", s_dout, 1);
    check("t1_valid", s_valid, 1);
    check("t1_count", s_cnt, 0);

    // 2: fill, overflow, full release timing, drain
    do_reset();
    for (int i = 1; i <= CAP; i++) s_step(1'b1, DW'(i), 1'b0);
    check("t2_full", s_full, 1);
    check("t2_count", s_cnt, CAP);
    check("t2_pf", s_pf, 1);
    s_step(1'b1, DW'(CAP+1), 1'b0);
    check("t2_overflow", s_ov, 1);
    check("t2_count_kept", s_cnt, CAP);
    s_step(1'b0, '0, 1'b1);
    check("t2_full_e0", s_full, 1);
    check("t2_pop_word", s_dout, 1);
    s_step(1'b1, DW'(999), 1'b0);
    check("t2_full_e1", s_full, 1);
    check("t2_interim_refused", s_ov, 1);
    s_step(1'b0, '0, 1'b0);
    check("t2_full_e2", s_full, 0);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) s_step(1'b0, '0, 1'b1);
    check("t2_drained", exp_q.size(), 0);

    // 3: sustained streaming at occupancy 10
    do_reset();
    for (int i = 0; i < 10; i++) s_step(1'b1, DW'(1000+i), 1'b0);
    for (int i = 0; i < NS; i++) s_step(1'b0, '0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      s_step(1'b1, DW'(1010+i), 1'b1);
      check("t3_valid", s_valid, 1);
      check("t3_dout", s_dout, DW'(1000+i));
      check("t3_count", s_cnt, 10);
    end

    // 4: first-word-fall-through
    do_reset();
    f_step(1'b1, DW'(36'hA), 1'b0);
    f_step(1'b1, DW'(36'hB), 1'b0);
    f_step(1'b0, '0, 1'b0);
    check("t4_dout_a", f_dout, 36'hA);
    check("t4_valid", f_valid, 1);
    check("t4_empty", f_empty, 0);
    f_step(1'b0, '0, 1'b1);
    check("t4_dout_b", f_dout, 36'hB);
    f_step(1'b0, '0, 1'b1);
    check("t4_empty_end", f_empty, 1);

    // 5: read from empty
    do_reset();
    s_step(1'b0, '0, 1'b1);
    check("t5_underflow", s_un, 1);
    check("t5_valid", s_valid, 0);
    check("t5_count", s_cnt, 0);

    // 6: reset with contents, then no stale data
    do_reset();
    for (int i = 0; i < 20; i++) s_step(1'b1, DW'(500+i), 1'b0);
    s_step(1'b0, '0, 1'b0);
    do_reset();
    s_step(1'b1, DW'(5), 1'b0);
    for (int i = 0; i < NS-1; i++) s_step(1'b0, '0, 1'b0);
    s_step(1'b0, '0, 1'b1);
    check("t6_dout", s_dout, 5);
    check("t6_valid", s_valid, 1);

    // random standard-mode traffic: fill-biased then drain-biased
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic wr, rd;
      if (i < 200) begin
        wr = ($urandom_range(0, 99) < 80);
        rd = ($urandom_range(0, 99) < 25);
      end else begin
        wr = ($urandom_range(0, 99) < 25);
        rd = ($urandom_range(0, 99) < 80);
      end
      s_step(wr, rand_word(), rd);
    end
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) s_step(1'b0, '0, 1'b1);

    // random FWFT traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic wr, rd;
      if (i < 200) begin
        wr = ($urandom_range(0, 99) < 80);
        rd = ($urandom_range(0, 99) < 30);
      end else begin
        wr = ($urandom_range(0, 99) < 30);
        rd = ($urandom_range(0, 99) < 80);
      end
      f_step(wr, rand_word(), rd);
    end
    for (int i = 0; i < 200 && f_q.size() > 0; i++) f_step(1'b0, '0, 1'b1);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
